inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/arm_pkg.sv | 93 +++++++++
 rtl/cond_eval.sv | 20 ++
 rtl/inst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_inst_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the instruction sequencer slice.
//
// Contents:
//   - bit-field positions inside the 32-bit instruction word
//   - instruction class codes (inst[27:26])
//   - ARM condition codes (inst[31:28])
//   - NZCV flag struct
//   - sequencer state enum
//   - cond_holds(): ARM condition evaluation against NZCV
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam int INST_W    = 32;
  localparam int FLAGS_W   = 4;

  // Instruction bit fields
  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int CLASS_MSB = 27;
  localparam int CLASS_LSB = 26;
  localparam int SBIT      = 20;   // "set flags" bit of data instructions

  typedef enum logic [1:0] {
    CLS_DATA   = 2'b00,
    CLS_LOAD   = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_UNDEF  = 2'b11
  } inst_class_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Flag vector ordering is {N,Z,C,V}, MSB first
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } seq_state_e;

  // ARM condition evaluation; AL always passes, NV never does.
  function automatic logic cond_holds(input cond_e c, input nzcv_t f);
    logic r;
    r = 1'b0;
    case (c)
      COND_EQ: r = f.z;
      COND_NE: r = !f.z;
      COND_CS: r = f.c;
      COND_CC: r = !f.c;
      COND_MI: r = f.n;
      COND_PL: r = !f.n;
      COND_VS: r = f.v;
      COND_VC: r = !f.v;
      COND_HI: r = f.c && !f.z;
      COND_LS: r = !f.c || f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = !f.z && (f.n == f.v);
      COND_LE: r = f.z || (f.n != f.v);
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational ARM condition-code check.
//
// Ports:
//   cond  [3:0]  in   condition field inst[31:28]
//   flags [3:0]  in   status flags {N,Z,C,V}
//   pass         out  1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  assign pass = cond_holds(cond_e'(cond), nzcv_t'(flags));

endmodule

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXEC [-> MEM -> WB].
// One instruction is accepted in IDLE, classified in DECODE by inst[27:26],
// executed (or skipped on a failed condition) in EXEC. Loads wait in MEM for
// mem_ack, then write back in WB. All strobes decode from the registered
// state plus the latched word; none is ever high in IDLE or DECODE.
//
// Configuration macro:
//   COND_EXEC_EN  defined   : inst[31:28] is evaluated against flags
//                 undefined : every condition (NV included) is treated as true
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   inst[31:0]    in   instruction word from fetch
//   inst_valid    in   inst holds a valid word
//   inst_ready    out  sequencer can accept (IDLE only, low while in reset)
//   flags[3:0]    in   {N,Z,C,V}, sampled during EXEC
//   mem_ack       in   load data ready (only looked at in MEM)
//   pc_en         out  advance PC (one pulse per instruction)
//   branch_taken  out  branch redirect
//   mem_rd        out  load request, held through MEM
//   rf_we         out  register file write
//   flags_we      out  flag write (data instruction with S bit)
//   illegal       out  undefined instruction class
//   busy          out  state is not IDLE
// -----------------------------------------------------------------------------
module inst_sequencer
  import arm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INST_W-1:0]  inst,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic [FLAGS_W-1:0] flags,
  input  logic               mem_ack,
  output logic               pc_en,
  output logic               branch_taken,
  output logic               mem_rd,
  output logic               rf_we,
  output logic               flags_we,
  output logic               illegal,
  output logic               busy
);

  seq_state_e        state_q, state_d;
  logic [INST_W-1:0] inst_q,  inst_d;
  inst_class_e       class_q, class_d;

  logic ce_pass;
  logic cond_pass;

  // ---------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------
  cond_eval u_cond_eval (
    .cond  (inst_q[COND_MSB:COND_LSB]),
    .flags (flags),
    .pass  (ce_pass)
  );

`ifdef COND_EXEC_EN
  assign cond_pass = ce_pass;
`else
  // Conditional execution compiled out: everything executes.
  logic unused_ce_pass;
  assign cond_pass      = 1'b1;
  assign unused_ce_pass = ce_pass;
`endif

  // Only the condition, class and S bit of the latched word are consumed here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_q[25:21], inst_q[19:0]};

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      class_q <= CLS_DATA;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      class_q <= class_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    class_d      = class_q;
    pc_en        = 1'b0;
    branch_taken = 1'b0;
    mem_rd       = 1'b0;
    rf_we        = 1'b0;
    flags_we     = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        class_d = inst_class_e'(inst_q[CLASS_MSB:CLASS_LSB]);
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!cond_pass) begin
          // Skipped instruction of any class: just step the PC.
          pc_en = 1'b1;
        end else begin
          case (class_q)
            CLS_DATA: begin
              rf_we    = 1'b1;
              pc_en    = 1'b1;
              flags_we = inst_q[SBIT];
            end
            CLS_BRANCH: begin
              branch_taken = 1'b1;
              pc_en        = 1'b1;
            end
            CLS_LOAD: begin
              // PC advances only after the write-back.
              mem_rd  = 1'b1;
              state_d = ST_MEM;
            end
            CLS_UNDEF: begin
              illegal = 1'b1;
              pc_en   = 1'b1;
            end
            default: begin
              pc_en = 1'b1;
            end
          endcase
        end
      end

      ST_MEM: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // inst_ready is held low while reset is asserted so nothing can be
  // handed over before the sequencer is running.
  assign inst_ready = (state_q == ST_IDLE) && reset_n;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
// Scoreboard bench: the driver pushes the expected outcome of each accepted
// instruction into a queue; a monitor tracks every transaction from handshake
// to its pc_en pulse and compares latency, strobes and pulse counts.
// Expectations depend on whether COND_EXEC_EN is defined.
// -----------------------------------------------------------------------------
module tb_inst_sequencer;

`ifdef COND_EXEC_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  flags;
  logic        mem_ack;
  logic        pc_en;
  logic        branch_taken;
  logic        mem_rd;
  logic        rf_we;
  logic        flags_we;
  logic        illegal;
  logic        busy;

  inst_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .flags        (flags),
    .mem_ack      (mem_ack),
    .pc_en        (pc_en),
    .branch_taken (branch_taken),
    .mem_rd       (mem_rd),
    .rf_we        (rf_we),
    .flags_we     (flags_we),
    .illegal      (illegal),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stb = {rf_we, flags_we, branch_taken, illegal} in the pc_en cycle
  typedef struct {
    logic [31:0] w;
    logic [3:0]  stb;
    int          lat;
    int          nrd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_len  = 2;    // mem_ack arrives in the ack_len-th mem_rd cycle
  bit   noise    = 1'b0; // drive mem_ack high whenever mem_rd is low
  int   stray    = 0;    // strobes seen outside any transaction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic monitor();
    bit          in_txn = 1'b0;
    int          cyc = 0;
    int          start = 0;
    int          n_rf = 0, n_fw = 0, n_br = 0, n_ill = 0, n_rd = 0, n_rdy = 0;
    logic [31:0] acc_w = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn = 1'b0;
        continue;
      end
      if (in_txn) begin
        n_rf  += int'(rf_we);
        n_fw  += int'(flags_we);
        n_br  += int'(branch_taken);
        n_ill += int'(illegal);
        n_rd  += int'(mem_rd);
        n_rdy += int'(inst_ready);
      end else if (pc_en || rf_we || flags_we || branch_taken || illegal || mem_rd) begin
        stray++;
      end
      if (pc_en && in_txn) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pc_en", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("accepted_inst", acc_w, e.w);
          check("latency", cyc - start, e.lat);
          check("strobes_at_pc_en", {28'd0, rf_we, flags_we, branch_taken, illegal}, {28'd0, e.stb});
          check("pulse_counts", {n_rf[7:0], n_fw[7:0], n_br[7:0], n_ill[7:0]},
                {7'd0, e.stb[3], 7'd0, e.stb[2], 7'd0, e.stb[1], 7'd0, e.stb[0]});
          check("mem_rd_cycles", n_rd, e.nrd);
          check("ready_low_while_busy", n_rdy, 32'd0);
          $display("txn inst=%h lat=%0d stb=%b mem_rd_cycles=%0d", acc_w, cyc - start,
                   {rf_we, flags_we, branch_taken, illegal}, n_rd);
        end
        in_txn = 1'b0;
      end
      if (inst_valid && inst_ready) begin
        in_txn = 1'b1;
        start  = cyc;
        acc_w  = inst;
        n_rf = 0; n_fw = 0; n_br = 0; n_ill = 0; n_rd = 0; n_rdy = 0;
      end
      cyc++;
    end
  endtask

  task automatic responder();
    int run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd) begin
        mem_ack = (run == ack_len - 1);
        run++;
      end else begin
        mem_ack = noise;
        run = 0;
      end
    end
  endtask

  task automatic issue(input logic [31:0] w, input logic [3:0] f, input int al,
                       input logic [3:0] stb, input int lat, input int nrd, input bit track);
    int k = 0;
    @(posedge clk);
    #1;
    while (!inst_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ready_before_issue", {31'd0, inst_ready}, 32'd1);
    if (track) exp_q.push_back('{w, stb, lat, nrd});
    inst       = w;
    flags      = f;
    ack_len    = al;
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  initial begin
    int snap;
    int k;
    reset_n    = 1'b1;
    inst_valid = 1'b0;
    inst       = '0;
    flags      = '0;
    mem_ack    = 1'b0;
    fork
      monitor();
      responder();
    join_none

    #2 reset_n = 1'b0;
    #1 check("reset_outputs",
             {24'd0, pc_en, branch_taken, mem_rd, rf_we, flags_we, illegal, busy, inst_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("idle_after_reset", {30'd0, inst_ready, busy}, 32'd2);

    // data / branch / load / undefined / conditional variants
    issue(32'hE0811002, 4'b0000, 2, 4'b1000, 2, 0, 1'b1);              // ADD AL
    issue(32'hE0911002, 4'b0000, 2, 4'b1100, 2, 0, 1'b1);              // ADDS AL
    issue(32'h0A000004, 4'b0100, 2, 4'b0010, 2, 0, 1'b1);              // BEQ, Z=1
    issue(32'h0A000004, 4'b0000, 2, CE ? 4'b0000 : 4'b0010, 2, 0, 1'b1); // BEQ, Z=0
    issue(32'hE5910000, 4'b0000, 4, 4'b1000, 6, 4, 1'b1);              // LDR, ack in 4th mem_rd cycle
    issue(32'hE5910000, 4'b0000, 2, 4'b1000, 4, 2, 1'b1);              // LDR, no wait
    issue(32'hEC000000, 4'b0000, 2, 4'b0001, 2, 0, 1'b1);              // class 11
    issue(32'hF0811002, 4'b0000, 2, CE ? 4'b0000 : 4'b1000, 2, 0, 1'b1); // ADD NV
    issue(32'hB0911002, 4'b1000, 2, 4'b1100, 2, 0, 1'b1);              // ADDS LT, N!=V
    issue(32'hD0811002, 4'b0000, 2, CE ? 4'b0000 : 4'b1000, 2, 0, 1'b1); // ADD LE, fails
    issue(32'hC0811002, 4'b1001, 2, 4'b1000, 2, 0, 1'b1);              // ADD GT, passes
    issue(32'h05910000, 4'b0000, 2, CE ? 4'b0000 : 4'b1000, CE ? 2 : 4, CE ? 0 : 2, 1'b1); // LDREQ

    // mem_ack toggling outside MEM must be ignored
    noise = 1'b1;
    issue(32'hE0811002, 4'b0000, 3, 4'b1000, 2, 0, 1'b1);
    issue(32'hE5910000, 4'b0000, 3, 4'b1000, 5, 3, 1'b1);
    noise = 1'b0;

    // reset in the middle of a load: no write-back may follow
    issue(32'hE5910000, 4'b0000, 100, 4'b0000, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mem_rd_in_mem", {30'd0, mem_rd, busy}, 32'd3);
    #2 reset_n = 1'b0;
    #1 check("abort_outputs",
             {24'd0, pc_en, branch_taken, mem_rd, rf_we, flags_we, illegal, busy, inst_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    snap = stray;
    repeat (6) @(posedge clk);
    #1;
    check("no_strobe_after_abort", stray - snap, 32'd0);
    check("idle_after_abort", {30'd0, inst_ready, busy}, 32'd2);
    issue(32'hE0811002, 4'b0000, 2, 4'b1000, 2, 0, 1'b1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("stray_strobes", stray, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
